// File: rtl/fp_mul_pack.sv
// rtl/fp_mul_pack.sv - binary32 multiplier back end: normalize, round-to-nearest-even, specials, pack
module fp_mul_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [47:0] mant_in,
    input  logic        is_nan,
    input  logic        is_inf,
    input  logic        is_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [9:0]  s1_exp_q;
    logic [46:0] s1_mant_q;
    logic        s1_nan_q;
    logic        s1_inf_q;
    logic        s1_zero_q;

    logic        s2_valid_q;
    logic [31:0] result_q;
    logic        overflow_q;
    logic        underflow_q;
    logic        inexact_q;

    logic        s1_load;
    logic        s2_load;
    logic [46:0] s1_mant_d;
    logic [9:0]  s1_exp_d;

    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [9:0]  exp_r;
    logic [31:0] result_d;
    logic        overflow_d;
    logic        underflow_d;
    logic        inexact_d;

    // Output register frees up when empty or drained; stage 1 follows it.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = !rst && s1_load;

    // The leading one sits at bit 47 or 46; only bits below it are kept.
    assign s1_mant_d = mant_in[47] ? mant_in[46:0] : {mant_in[45:0], 1'b0};
    assign s1_exp_d  = mant_in[47] ? exp_in + 10'd1 : exp_in;

    assign frac     = s1_mant_q[46:24];
    assign guard    = s1_mant_q[23];
    assign sticky   = |s1_mant_q[22:0];
    assign round_up = guard && (sticky || frac[0]);
    assign frac_sum = {1'b0, frac} + {23'd0, round_up};
    assign exp_r    = s1_exp_q + {9'd0, frac_sum[23]};

    always_comb begin
        result_d    = {s1_sign_q, exp_r[7:0], frac_sum[22:0]};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = guard | sticky;
        if (s1_nan_q) begin
            result_d  = 32'h7FC0_0000;
            inexact_d = 1'b0;
        end else if (s1_inf_q) begin
            result_d  = {s1_sign_q, 8'hFF, 23'd0};
            inexact_d = 1'b0;
        end else if (s1_zero_q) begin
            result_d  = {s1_sign_q, 31'd0};
            inexact_d = 1'b0;
        end else if ($signed(exp_r) >= 10'sd255) begin
            result_d   = {s1_sign_q, 8'hFF, 23'd0};
            overflow_d = 1'b1;
            inexact_d  = 1'b1;
        end else if ($signed(exp_r) <= 10'sd0) begin
            result_d    = {s1_sign_q, 31'd0};
            underflow_d = 1'b1;
            inexact_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 10'd0;
            s1_mant_q   <= 47'd0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= sign_in;
                    s1_exp_q  <= s1_exp_d;
                    s1_mant_q <= s1_mant_d;
                    s1_nan_q  <= is_nan;
                    s1_inf_q  <= is_inf;
                    s1_zero_q <= is_zero;
                end
            end
            // Result only changes on a real load, so it stays put while stalled.
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q    <= result_d;
                    overflow_q  <= overflow_d;
                    underflow_q <= underflow_d;
                    inexact_q   <= inexact_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

endmodule

// File: doc/fp_mul_pack.md
# fp_mul_pack

Back end of the single-precision floating-point multiplier datapath. The sign stage XORs the operand sign bits and the exponent/mantissa stages produce a biased exponent sum and a raw 48-bit significand product. This block takes those raw fields through a two-stage valid/ready pipeline. It normalizes, rounds to nearest-even, handles specials and overflow/underflow, and packs the IEEE-754 binary32 result.

## Interface
- No parameters; widths fixed to binary32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream fields valid
- in_ready  out  1  block can accept this cycle
- sign_in  in  1  product sign (in1[31] ^ in2[31])
- exp_in  in  10  signed two's-complement biased exponent, e1 + e2 − 127
- mant_in  in  48  product of the two 24-bit significands, hidden bits included
- is_nan / is_inf / is_zero  in  1 each  special-case class, decoded upstream; priority nan > inf > zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  32  packed binary32 product
- overflow / underflow / inexact  out  1 each  exception flags, qualified by out_valid

## Operation
- Handshake:
  - Transfer occurs when valid && ready on the same rising edge.
  - in_ready = !rst && (!s1_valid || !s2_valid || out_ready). This is combinational, with no bubble under full throughput.
  - Once out_valid is asserted, result and flags are held stable until out_ready.
- Stage 1 (normalize):
  - If mant_in[47]: m = mant_in, e = exp_in + 1.
  - Else: m = mant_in << 1, e = exp_in.
  - Specials, sign, and e are registered with m.
- Stage 2 (round/pack):
  - Fields: frac = m[46:24], guard = m[23], sticky = |m[22:0].
  - Round up when guard && (sticky || frac[0]).
  - If frac is all-ones and rounds up, frac becomes 0 and e is incremented.
- Result selection, in priority order:
  - NaN: result = 32'h7FC00000. Sign is ignored and all flags are 0.
  - Inf: result = {sign, 8'hFF, 23'h0}. Flags 0.
  - Zero: result = {sign, 31'h0}. Flags 0.
  - e ≥ 255 after rounding: {sign, 8'hFF, 0}, overflow = 1, inexact = 1.
  - e ≤ 0 after rounding: flush to signed zero {sign, 31'h0}, underflow = 1, inexact = 1. No subnormals are produced.
  - Otherwise: {sign, e[7:0], frac}, inexact = guard | sticky.
- Arithmetic: e is carried at 10 bits signed throughout. Comparisons are signed. An input range of −127..383 cannot wrap.
- Reset:
  - s1_valid = s2_valid = 0, out_valid = 0, result = 32'h0, all flags 0, in_ready = 0 while rst is high.
  - Reset mid-operation discards both stages. No output is produced for in-flight data.

## Timing
- Latency: a transfer accepted on edge N appears with out_valid = 1 after edge N+1, i.e. two cycles.
- Throughput: one result per cycle while out_ready = 1.
- Stage 2 loads whenever it is empty or its output is consumed that cycle.
- Stage 1 loads whenever stage 1 is empty or advancing that cycle.
- Simultaneous input acceptance and output consumption with both stages full: all registers shift in the same edge, with no loss and no duplication.
- Backpressure with out_ready = 0: at most two items are buffered, then in_ready = 0.
- First cycle after rst deasserts: in_ready = 1, out_valid = 0.

## Test plan
- 1.0×1.0: exp_in = 127, mant_in = 48'h400000000000 -> result 32'h3F800000 after 2 cycles, all flags 0.
- 1.5×1.5: exp_in = 127, mant_in = 48'h900000000000 -> 32'h40100000, inexact = 0. Same with sign_in = 1 -> 32'hC0100000.
- Rounding, all with exp_in = 127:
  - Tie, even LSB: mant_in = 48'h400000400000 -> 32'h3F800000, inexact = 1.
  - Tie, odd LSB: 48'h400000C00000 -> 32'h3F800002.
  - Rounding carry: 48'h7FFFFFC00000 -> 32'h40000000.
- Limits:
  - exp_in = 254, mant_in = 48'h900000000000 -> 32'h7F800000, overflow = 1.
  - exp_in = 0, mant_in = 48'h400000000000, sign_in = 1 -> 32'h80000000, underflow = 1.
  - is_nan = 1 -> 32'h7FC00000.
  - is_inf with sign 1 -> 32'hFF800000.
- Backpressure: stream 6 back-to-back inputs with out_ready low for cycles 3–5.
  - in_ready drops after the 2nd buffered item.
  - All 6 results emerge in order, unchanged while stalled, with none lost or duplicated.
- Reset: assert rst while both stages are full -> next cycle out_valid = 0, result = 0, flags 0. The first post-reset input yields its result exactly 2 cycles after acceptance.
